retire_rob: RTL

//  In-order retire buffer that returns physical registers to the rename freelist.
//  - Dispatch pushes each renamed op: dst flag, previous mapping (old_tag), new mapping (new_tag).
//  - Execute marks entries complete by ROB index; retire drains the head in order.
//  - Retire drives free_req/free_tag with old_tag. On flush, a walk-back frees every in-flight new_tag.

---
 rtl/retire_rob.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/retire_rob.sv
// ---------------------------------------------------------------------------
// retire_rob
//
// In-order retire buffer that hands physical registers back to the rename
// freelist.
//
// Dispatch pushes one renamed op per cycle at the tail. The op carries a
// destination flag, the previous mapping of its destination (old_tag) and the
// newly allocated mapping (new_tag). Execute marks entries complete by ROB
// index. Retire drains the head in program order. Each retiring op with a
// destination frees its old_tag.
//
// On flush, the buffer walks back from the youngest entry to the head. Every
// in-flight new_tag is freed, one per cycle. Dispatch is held off until the
// walk reaches the head.
//
// Optional feature (macro RETIRE_CMPL_BYPASS_EN):
//   When defined, a completion that targets the head counts as complete in
//   the same cycle, so the head can retire in its completion cycle. When
//   undefined, a completion is registered first. The head then retires no
//   earlier than the cycle after cmpl_valid.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 4)
//   IDX_W  index width, clog2(DEPTH)
//   TAG_W  physical register tag width
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   disp_valid      dispatch request
//   disp_ready      entry available and not recovering
//   disp_has_dst    op writes a register
//   disp_old_tag    previous mapping of dst, freed at retire
//   disp_new_tag    newly allocated tag, freed on flush
//   disp_idx        index given to this dispatch (tail)
//   cmpl_valid      completion strobe
//   cmpl_idx        index of the completing entry
//   flush           squash all un-retired entries
//   free_full       freelist full; holds off any free
//   free_req        a tag is freed this cycle
//   free_tag        tag being freed
//   retire_valid    head retires this cycle
//   retire_idx      index retiring (head)
//   count           number of occupied entries
//   empty, full     count == 0 / count == DEPTH
// ---------------------------------------------------------------------------
module retire_rob #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic             disp_has_dst,
  input  logic [TAG_W-1:0] disp_old_tag,
  input  logic [TAG_W-1:0] disp_new_tag,
  output logic [IDX_W-1:0] disp_idx,
  input  logic             cmpl_valid,
  input  logic [IDX_W-1:0] cmpl_idx,
  input  logic             flush,
  input  logic             free_full,
  output logic             free_req,
  output logic [TAG_W-1:0] free_tag,
  output logic             retire_valid,
  output logic [IDX_W-1:0] retire_idx,
  output logic [IDX_W:0]   count,
  output logic             empty,
  output logic             full
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } state_t;

  localparam logic [IDX_W:0]   DEPTH_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             head_q, head_d;
  logic [IDX_W-1:0]             tail_q, tail_d;
  logic [IDX_W-1:0]             walk_q, walk_d;
  logic [IDX_W:0]               count_q, count_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             cmpl_q, cmpl_d;
  logic [DEPTH-1:0]             has_dst_q, has_dst_d;
  logic [DEPTH-1:0][TAG_W-1:0]  old_tag_q, old_tag_d;
  logic [DEPTH-1:0][TAG_W-1:0]  new_tag_q, new_tag_d;

  logic is_idle;
  logic head_done;
  logic retire_fire;
  logic flush_start;
  logic disp_fire;
  logic cmpl_fire;
  logic walk_adv;

  // Control decode and output drive. Every output comes from registered
  // state plus the free_full/flush/cmpl inputs. Only the optional head
  // bypass looks at cmpl. A flush that starts a walk-back suppresses the
  // dispatch and the retire of its own cycle. The retire side already sees
  // flush directly. The walk only advances past a destination-carrying entry
  // when the freelist can take the tag. This way no free is ever dropped.
  always_comb begin
    is_idle   = (state_q == IDLE);
    full      = (count_q == DEPTH_CNT);
    empty     = (count_q == '0);
    count     = count_q;
    disp_idx  = tail_q;
    retire_idx = head_q;

    disp_ready = is_idle && !full;

    head_done = cmpl_q[head_q];
`ifdef RETIRE_CMPL_BYPASS_EN
    if (cmpl_valid && (cmpl_idx == head_q)) begin
      head_done = 1'b1;
    end
`endif

    retire_fire = is_idle && valid_q[head_q] && head_done && !flush &&
                  !(has_dst_q[head_q] && free_full);
    retire_valid = retire_fire;

    flush_start = is_idle && flush && !empty;
    disp_fire   = disp_valid && disp_ready && !flush_start;
    cmpl_fire   = cmpl_valid && is_idle && valid_q[cmpl_idx];
    walk_adv    = !is_idle && (!has_dst_q[walk_q] || !free_full);

    if (is_idle) begin
      free_req = retire_fire && has_dst_q[head_q];
      free_tag = old_tag_q[head_q];
    end else begin
      free_req = has_dst_q[walk_q] && !free_full;
      free_tag = new_tag_q[walk_q];
    end
  end

  // Next-state computation for pointers, per-entry state and the FSM. In
  // normal operation, completions, retires and dispatches are applied in that
  // order. They never collide on one entry. A completion for the tail is
  // ignored because that entry is not valid yet. Dispatch cannot target the
  // head while it is retiring because the buffer would have to be full. On
  // the last walk step the walk has reached the head. The tail then snaps
  // back to the head and the buffer is empty again.
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    walk_d    = walk_q;
    count_d   = count_q;
    valid_d   = valid_q;
    cmpl_d    = cmpl_q;
    has_dst_d = has_dst_q;
    old_tag_d = old_tag_q;
    new_tag_d = new_tag_q;

    if (cmpl_fire) begin
      cmpl_d[cmpl_idx] = 1'b1;
    end

    if (retire_fire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + IDX_ONE;
    end

    if (disp_fire) begin
      valid_d[tail_q]   = 1'b1;
      cmpl_d[tail_q]    = 1'b0;
      has_dst_d[tail_q] = disp_has_dst;
      old_tag_d[tail_q] = disp_old_tag;
      new_tag_d[tail_q] = disp_new_tag;
      tail_d            = tail_q + IDX_ONE;
    end

    if (disp_fire && !retire_fire) begin
      count_d = count_q + CNT_ONE;
    end else if (!disp_fire && retire_fire) begin
      count_d = count_q - CNT_ONE;
    end

    if (flush_start) begin
      state_d = RECOVER;
      walk_d  = tail_q - IDX_ONE;
    end

    if (walk_adv) begin
      valid_d[walk_q] = 1'b0;
      if (walk_q == head_q) begin
        state_d = IDLE;
        tail_d  = head_q;
        count_d = '0;
      end else begin
        walk_d = walk_q - IDX_ONE;
      end
    end
  end

  // All state lives in this one register block. Reset clears everything at
  // once, including a walk-back in progress. No pending free survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      walk_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      cmpl_q    <= '0;
      has_dst_q <= '0;
      old_tag_q <= '0;
      new_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      walk_q    <= walk_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      cmpl_q    <= cmpl_d;
      has_dst_q <= has_dst_d;
      old_tag_q <= old_tag_d;
      new_tag_q <= new_tag_d;
    end
  end

endmodule
